dram_write_arbiter: RTL and testbench
=====================================

# dram_write_arbiter

Merges the per-TileAccumUnit DRAM write channels into one DRAM write port. The block sits directly downstream of the multi-core top level: its input side connects to `dramw_rdys/dramw_acks/o_dramwas/o_dramwds/o_dramw_masks`, and its output side drives the single memory-controller write port. Arbitration is round-robin with a one-entry registered output stage. Sustained throughput is one write per cycle.

## Interface
- `N_PORT`, 2: number of TAU write channels (equals `N_TAU`).
- `GBW`, 32: global address width.
- `DBW`, 16: data word width.
- `CSIZE`, 32: words per write beat.
- `PID_BW`, `$clog2(N_PORT)` (min 1): source-id width.

Ports (rdy/ack: sender raises rdy and holds payload; transfer occurs on rdy&&ack):
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_rdys` in N_PORT: per-port write request.
- `o_acks` out N_PORT: per-port acceptance; at most one bit high per cycle.
- `i_was` in GBW×[N_PORT]: per-port write address.
- `i_wds` in DBW×[CSIZE]×[N_PORT]: per-port write data.
- `i_wmasks` in CSIZE×[N_PORT]: per-port byte/word enable.
- `o_rdy` out 1: merged write valid.
- `i_ack` in 1: memory side accepts.
- `o_wa` out GBW: merged address.
- `o_wd` out DBW×[CSIZE]: merged data.
- `o_wmask` out CSIZE: merged mask.
- `o_src` out PID_BW: index of the port that issued the current beat.

## Operation
- Output stage is one register slot with two states:
  - EMPTY (`o_rdy`=0).
  - FULL (`o_rdy`=1).
- `can_load` = EMPTY | (FULL & `i_ack`).
- Grant search: scan ports `last+1, last+2, …` modulo N_PORT. The first with `i_rdys[p]`=1 wins (`g`).
- `o_acks[g]` = `can_load` & any request. Combinational, and depends on `i_ack` and `i_rdys`.
- On `o_acks[g]`:
  - Load `i_was[g]`, `i_wds[g]`, `i_wmasks[g]` and `o_src`=`g` into the slot.
  - Set `last`=`g`.
  - Slot becomes or stays FULL.
- FULL & `i_ack` with no request: slot goes EMPTY. Payload registers keep their stale values.
- FULL & !`i_ack`: slot contents and `o_rdy` are frozen. All `o_acks`=0.
- `last` changes only on a grant. A port that keeps requesting therefore cannot starve others: each other requester is served within N_PORT grants.
- Payload is passed through bit-exact, with no width conversion. The mask is not interpreted.
- Wrap-around: if `last`=N_PORT-1, the search starts at port 0.
- Requests are never dropped or duplicated. Each input rdy&&ack event produces exactly one output rdy&&ack event, in grant order.

## Timing
- Reset (async assert, `i_rst`=0):
  - `o_rdy`=0, `o_wa`=0, `o_wd`=0, `o_wmask`=0, `o_src`=0.
  - `last`=N_PORT-1, so port 0 has first priority.
  - `o_acks`=0 while in reset.
- Reset deassert is used synchronously. The first grant is possible in the first cycle after deassert.
- Latency: input accepted in cycle t → `o_rdy`=1 with that payload from cycle t+1.
- Back-to-back: with `i_ack`=1 continuously and requests present, one grant per cycle and `o_rdy` stays 1.
- Reset mid-transfer: the slot contents are discarded, with no output beat. Upstream ports whose ack did not fire keep their request pending and are served after reset.
- Simultaneous output drain and new grant in the same cycle is legal. The slot is replaced with no bubble.

## Test plan
- Single port: port 1 requests addr 0x100, mask 0xFFFFFFFF, `i_ack`=1 → `o_acks`=0b10 at cycle 0; at cycle 1 `o_rdy`=1, `o_wa`=0x100, `o_src`=1; at cycle 2 `o_rdy`=0.
- Contention: both ports request continuously (addr 0x10·k on port 0, 0x20·k on port 1), `i_ack`=1 → output `o_src` sequence is 0,1,0,1,… and every address appears exactly once, in order per port.
- Backpressure: the slot is full with port 0 data and `i_ack`=0 for 5 cycles while port 1 requests → `o_wa/o_wd/o_wmask/o_src` are stable, `o_acks`=0; when `i_ack`=1 port 1 is acked in that same cycle and appears the next cycle.
- Mask/data integrity: random `i_wds`, mask 0x0000FFFF on port 0 → `o_wd` and `o_wmask` match bit-exact; scoreboard over 1000 random beats with random `i_ack` shows no loss or duplication.
- Reset mid-operation: `o_rdy`=1, then `i_rst`=0 for 2 cycles → `o_rdy`=0 and all outputs are 0 immediately (asynchronously); after release with port 0 and port 1 requesting, port 0 is granted first.
- Fairness wrap: with N_PORT=4, only ports 3 and 0 request and last=3 → grant order is 0,3,0,3.

Source files
------------

// File: rtl/dram_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// dram_write_arbiter_if
//   Bundles the N_PORT upstream TAU write channels and the single merged
//   memory-controller write port handled by dram_write_arbiter.
//   Handshake on both sides is rdy/ack: the sender raises rdy and holds its
//   payload, and a transfer happens on a cycle where rdy && ack.
//
//   Upstream (one lane per TAU):
//     i_rdys   [N_PORT]              write request per port
//     o_acks   [N_PORT]              acceptance per port (one-hot or zero)
//     i_was    [N_PORT][GBW]         write address per port
//     i_wds    [N_PORT][CSIZE][DBW]  write data beat per port
//     i_wmasks [N_PORT][CSIZE]       word enables per port
//   Downstream (memory controller):
//     o_rdy    merged write valid       i_ack   memory side accepts
//     o_wa     merged address           o_wd    merged data beat
//     o_wmask  merged mask              o_src   port that issued the beat
//
//   Modports:
//     slave  - the arbiter's view (drives acks and the merged port)
//     master - the environment's view (drives requests and i_ack)
// ---------------------------------------------------------------------------
interface dram_write_arbiter_if #(
  parameter int N_PORT = 2,
  parameter int GBW    = 32,
  parameter int DBW    = 16,
  parameter int CSIZE  = 32,
  parameter int PID_BW = (N_PORT > 1) ? $clog2(N_PORT) : 1
);

  logic [N_PORT-1:0]                      i_rdys;
  logic [N_PORT-1:0]                      o_acks;
  logic [N_PORT-1:0][GBW-1:0]             i_was;
  logic [N_PORT-1:0][CSIZE-1:0][DBW-1:0]  i_wds;
  logic [N_PORT-1:0][CSIZE-1:0]           i_wmasks;

  logic                                   o_rdy;
  logic                                   i_ack;
  logic [GBW-1:0]                         o_wa;
  logic [CSIZE-1:0][DBW-1:0]              o_wd;
  logic [CSIZE-1:0]                       o_wmask;
  logic [PID_BW-1:0]                      o_src;

  modport slave (
    input  i_rdys, i_was, i_wds, i_wmasks, i_ack,
    output o_acks, o_rdy, o_wa, o_wd, o_wmask, o_src
  );

  modport master (
    output i_rdys, i_was, i_wds, i_wmasks, i_ack,
    input  o_acks, o_rdy, o_wa, o_wd, o_wmask, o_src
  );

endinterface

// File: rtl/dram_write_arbiter.sv
// ---------------------------------------------------------------------------
// dram_write_arbiter
//   Merges N_PORT TAU DRAM write channels into one memory-controller write
//   port. Round-robin arbitration feeds a single registered output slot, so
//   a beat accepted in cycle t is presented downstream from cycle t+1, and
//   with i_ack held high the block sustains one write per cycle.
//
//   Ports:
//     i_clk   clock
//     i_rst   asynchronous active-low reset
//     io_bus  dram_write_arbiter_if.slave
//               upstream:   i_rdys / o_acks / i_was / i_wds / i_wmasks
//               downstream: o_rdy / i_ack / o_wa / o_wd / o_wmask / o_src
// ---------------------------------------------------------------------------
module dram_write_arbiter #(
  parameter int N_PORT = 2,
  parameter int GBW    = 32,
  parameter int DBW    = 16,
  parameter int CSIZE  = 32,
  parameter int PID_BW = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  dram_write_arbiter_if.slave    io_bus
);

  // After reset the "previous winner" is the highest port so that port 0
  // is first in line.
  localparam logic [PID_BW-1:0] LAST_RST = PID_BW'(N_PORT - 1);

  // Output slot and arbitration state
  logic                        r_full;
  logic [PID_BW-1:0]           r_last;
  logic [PID_BW-1:0]           r_src;
  logic [GBW-1:0]              r_wa;
  logic [CSIZE-1:0][DBW-1:0]   r_wd;
  logic [CSIZE-1:0]            r_wmask;

  logic                        w_can_load;
  logic                        w_any;
  logic                        w_grant;
  logic                        w_found;
  logic [PID_BW-1:0]           w_gnt;
  logic [N_PORT-1:0]           w_acks;

  // The slot can take a new beat when it is empty or is being drained now.
  assign w_can_load = !r_full || io_bus.i_ack;
  assign w_any      = |io_bus.i_rdys;
  // i_rst gating keeps every ack low while reset is asserted.
  assign w_grant    = i_rst && w_can_load && w_any;

  // Round-robin search starting just above r_last. Ports above the previous
  // winner are considered first, then the wrap-around ports 0..r_last; this
  // is the same order as scanning last+1, last+2, ... modulo N_PORT.
  always_comb begin : grant_search
    w_found = 1'b0;
    w_gnt   = '0;
    for (int p = 0; p < N_PORT; p++) begin
      if (!w_found && io_bus.i_rdys[p] && (p > int'(r_last))) begin
        w_found = 1'b1;
        w_gnt   = PID_BW'(p);
      end
    end
    for (int p = 0; p < N_PORT; p++) begin
      if (!w_found && io_bus.i_rdys[p]) begin
        w_found = 1'b1;
        w_gnt   = PID_BW'(p);
      end
    end
  end

  always_comb begin : ack_decode
    w_acks = '0;
    if (w_grant) begin
      w_acks[w_gnt] = 1'b1;
    end
  end

  assign io_bus.o_acks = w_acks;

  // ---- output slot register ----
  // A grant reloads the slot even when it is being drained in the same
  // cycle, which gives back-to-back beats without a bubble. A drain with no
  // new grant only clears r_full; the payload keeps its stale value.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_full  <= 1'b0;
      r_last  <= LAST_RST;
      r_src   <= '0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_wmask <= '0;
    end else if (w_grant) begin
      r_full  <= 1'b1;
      r_last  <= w_gnt;
      r_src   <= w_gnt;
      r_wa    <= io_bus.i_was[w_gnt];
      r_wd    <= io_bus.i_wds[w_gnt];
      r_wmask <= io_bus.i_wmasks[w_gnt];
    end else if (r_full && io_bus.i_ack) begin
      r_full  <= 1'b0;
    end
  end

  assign io_bus.o_rdy   = r_full;
  assign io_bus.o_wa    = r_wa;
  assign io_bus.o_wd    = r_wd;
  assign io_bus.o_wmask = r_wmask;
  assign io_bus.o_src   = r_src;

endmodule

// File: tb/tb_dram_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_write_arbiter
//   Self-checking bench for dram_write_arbiter. A two-port instance is driven
//   through a reference grant model and a scoreboard queue of expected output
//   beats; a four-port instance exercises the wrap-around fairness case.
// ---------------------------------------------------------------------------
module tb_dram_write_arbiter;

  localparam int GBW   = 32;
  localparam int DBW   = 16;
  localparam int CSIZE = 32;
  localparam int WDW   = DBW * CSIZE;

  typedef struct packed {
    logic [GBW-1:0]   wa;
    logic [WDW-1:0]   wd;
    logic [CSIZE-1:0] m;
    logic [0:0]       src;
  } beat_t;

  logic clk;
  logic rst_n;

  dram_write_arbiter_if #(.N_PORT(2), .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE)) b2 ();
  dram_write_arbiter_if #(.N_PORT(4), .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE)) b4 ();

  dram_write_arbiter #(.N_PORT(2), .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE)) u_dut2 (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .io_bus (b2)
  );

  dram_write_arbiter #(.N_PORT(4), .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE)) u_dut4 (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .io_bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk;
  int         n_fail;
  int         n_push;
  int         n_pop;
  beat_t      sb[$];
  logic [0:0] m_last;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WDW-1:0] rnd_wd();
    logic [WDW-1:0] r;
    for (int i = 0; i < WDW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Round-robin reference for two ports: try last+1 first, then last.
  // Returns {found, port}.
  function automatic logic [1:0] pick(input logic [1:0] rq, input logic [0:0] last);
    logic [0:0] c;
    c = last + 1'b1;
    if (rq[c]) return {1'b1, c};
    c = last;
    if (rq[c]) return {1'b1, c};
    return 2'b00;
  endfunction

  task automatic load(input logic [0:0] p, input logic [GBW-1:0] wa,
                      input logic [WDW-1:0] wd, input logic [CSIZE-1:0] m);
    b2.i_was[p]    = wa;
    b2.i_wds[p]    = wd;
    b2.i_wmasks[p] = m;
    b2.i_rdys[p]   = 1'b1;
  endtask

  // One clock of the two-port instance: check acks and the output slot at
  // the falling edge, advance the model, then retire the granted request.
  task automatic cyc();
    logic [1:0] pk;
    logic [1:0] exp_acks;
    beat_t      e;
    beat_t      nb;
    @(negedge clk);
    pk       = (sb.size() == 0 || b2.i_ack) ? pick(b2.i_rdys, m_last) : 2'b00;
    exp_acks = pk[1] ? (2'b01 << pk[0]) : 2'b00;
    chk("acks", 512'(b2.o_acks), 512'(exp_acks));
    chk("rdy", 512'(b2.o_rdy), 512'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb[0];
      chk("wa", 512'(b2.o_wa), 512'(e.wa));
      chk("wd", 512'(b2.o_wd), 512'(e.wd));
      chk("wmask", 512'(b2.o_wmask), 512'(e.m));
      chk("src", 512'(b2.o_src), 512'(e.src));
      if (b2.i_ack) begin
        void'(sb.pop_front());
        n_pop++;
      end
    end
    if (pk[1]) begin
      nb.wa  = b2.i_was[pk[0]];
      nb.wd  = b2.i_wds[pk[0]];
      nb.m   = b2.i_wmasks[pk[0]];
      nb.src = pk[0];
      sb.push_back(nb);
      m_last = pk[0];
      n_push++;
    end
    @(posedge clk);
    #1;
    if (pk[1]) b2.i_rdys[pk[0]] = 1'b0;
  endtask

  int         kk0;
  int         kk1;
  int         base;
  int         issued;
  int         cycles;
  logic [3:0] fa[4];
  logic [1:0] fs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_push = 0;
    n_pop  = 0;
    m_last = 1'b1;
    rst_n  = 1'b0;
    b2.i_rdys = 2'b11;  b2.i_ack = 1'b1;
    b2.i_was = '0;      b2.i_wds = '0;    b2.i_wmasks = '0;
    b4.i_rdys = 4'b1111; b4.i_ack = 1'b1;
    b4.i_was = '0;      b4.i_wds = '0;    b4.i_wmasks = '0;

    // Reset state: outputs cleared and no acks despite pending requests
    #12;
    chk("rst_rdy", 512'(b2.o_rdy), 512'(0));
    chk("rst_wa", 512'(b2.o_wa), 512'(0));
    chk("rst_wd", 512'(b2.o_wd), 512'(0));
    chk("rst_wmask", 512'(b2.o_wmask), 512'(0));
    chk("rst_src", 512'(b2.o_src), 512'(0));
    chk("rst_acks", 512'(b2.o_acks), 512'(0));
    chk("rst_acks4", 512'(b4.o_acks), 512'(0));
    b2.i_rdys = 2'b00;
    b4.i_rdys = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single port 1 beat
    load(1'b1, 32'h100, rnd_wd(), 32'hFFFF_FFFF);
    cyc();
    cyc();
    cyc();

    // Contention: both ports stream 8 beats each
    kk0 = 1;
    kk1 = 1;
    for (int c = 0; c < 40; c++) begin
      if (!b2.i_rdys[0] && kk0 <= 8) begin
        load(1'b0, 32'(16 * kk0), rnd_wd(), $urandom);
        kk0++;
      end
      if (!b2.i_rdys[1] && kk1 <= 8) begin
        load(1'b1, 32'(32 * kk1), rnd_wd(), $urandom);
        kk1++;
      end
      if (b2.i_rdys == 2'b00 && sb.size() == 0) break;
      cyc();
    end
    chk("cont_done", 512'(sb.size()), 512'(0));
    chk("cont_cnt", 512'(n_pop), 512'(17));

    // Backpressure: slot holds port 0 while port 1 waits
    load(1'b0, 32'h300, rnd_wd(), 32'hA5A5_A5A5);
    cyc();
    b2.i_ack = 1'b0;
    load(1'b1, 32'h400, rnd_wd(), 32'h5A5A_5A5A);
    repeat (5) cyc();
    b2.i_ack = 1'b1;
    cyc();
    cyc();
    cyc();

    // Random traffic, random downstream ack
    base   = n_push;
    issued = 0;
    cycles = 0;
    while ((n_push - base) < 1000 && cycles < 20000) begin
      if (!b2.i_rdys[0] && issued < 1000 && $urandom_range(0, 3) != 0) begin
        load(1'b0, $urandom, rnd_wd(), 32'h0000_FFFF);
        issued++;
      end
      if (!b2.i_rdys[1] && issued < 1000 && $urandom_range(0, 3) != 0) begin
        load(1'b1, $urandom, rnd_wd(), $urandom);
        issued++;
      end
      b2.i_ack = 1'($urandom_range(0, 1));
      cyc();
      cycles++;
    end
    chk("rand_beats", 512'(n_push - base), 512'(1000));
    b2.i_ack = 1'b1;
    for (int c = 0; c < 5 && sb.size() != 0; c++) cyc();
    chk("rand_drain", 512'(sb.size()), 512'(0));
    chk("rand_balance", 512'(n_pop), 512'(n_push));

    // Reset while the slot is full and both ports are requesting
    b2.i_ack = 1'b0;
    load(1'b0, 32'h500, rnd_wd(), 32'h1234_5678);
    cyc();
    load(1'b0, 32'h600, rnd_wd(), 32'h0F0F_0F0F);
    load(1'b1, 32'h700, rnd_wd(), 32'hF0F0_F0F0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_rdy", 512'(b2.o_rdy), 512'(0));
    chk("mrst_wa", 512'(b2.o_wa), 512'(0));
    chk("mrst_wd", 512'(b2.o_wd), 512'(0));
    chk("mrst_wmask", 512'(b2.o_wmask), 512'(0));
    chk("mrst_src", 512'(b2.o_src), 512'(0));
    sb.delete();
    m_last = 1'b1;
    b2.i_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mrst_acks", 512'(b2.o_acks), 512'(0));
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("mrst_drain", 512'(sb.size()), 512'(0));

    // Fairness wrap on the four-port instance: ports 3 and 0, last = 3
    fa[0] = 4'b0001; fa[1] = 4'b1000; fa[2] = 4'b0001; fa[3] = 4'b1000;
    fs[0] = 2'd0;    fs[1] = 2'd3;    fs[2] = 2'd0;    fs[3] = 2'd3;
    b4.i_rdys = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) chk("fair_ack", 512'(b4.o_acks), 512'(fa[i]));
      if (i > 0) chk("fair_src", 512'(b4.o_src), 512'(fs[i-1]));
      @(posedge clk);
      #1;
    end
    b4.i_rdys = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
